// File: rtl/audio_output_serial_if.sv
// rtl/audio_output_serial_if.sv - sample handshake between an audio source and the serial DAC driver
interface audio_output_serial_if;
  logic [11:0] sample;
  logic        sample_valid;
  logic        sample_ready;

  modport master (output sample, output sample_valid, input sample_ready);
  modport slave  (input sample, input sample_valid, output sample_ready);
endinterface

// File: rtl/audio_output_serial.sv
// rtl/audio_output_serial.sv - one-entry buffered 16-bit serial DAC frame generator (SYNC/DIN/SCLK)
module audio_output_serial #(
  parameter int         HALF_PERIOD = 5,
  parameter int         GAP_CYCLES  = 10,
  parameter logic [1:0] PD_MODE     = 2'b00
) (
  input  logic                         clock,
  input  logic                         reset,
  audio_output_serial_if.slave         s_if,
  output logic                         busy,
  output logic                         J_DA_Pin1,
  output logic                         J_DA_Pin2,
  output logic                         J_DA_Pin4
);

  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, START, SHIFT, GAP} state_t;

  state_t      r_state;
  logic [11:0] r_buf_data;
  logic        r_buf_full;
  logic [15:0] r_shift;
  logic [3:0]  r_bit_cnt;
  logic [PW-1:0] r_phase;
  logic [GW-1:0] r_gap;
  logic        r_sync;
  logic        r_sclk;
  logic        r_din;
  logic        r_busy;

  logic        w_accept;
  logic        w_phase_end;
  logic        w_gap_end;
  logic        w_load;
  logic [15:0] w_frame;

  assign s_if.sample_ready = ~r_buf_full;
  assign w_accept    = s_if.sample_valid & ~r_buf_full;
  assign w_phase_end = (r_phase == PW'(HALF_PERIOD - 1));
  assign w_gap_end   = (r_gap == GW'(GAP_CYCLES - 1));
  assign w_load      = r_buf_full & ((r_state == IDLE) | ((r_state == GAP) & w_gap_end));
  assign w_frame     = {2'b00, PD_MODE, r_buf_data};

  assign busy      = r_busy;
  assign J_DA_Pin1 = r_sync;
  assign J_DA_Pin2 = r_din;
  assign J_DA_Pin4 = r_sclk;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_buf_data <= '0;
      r_buf_full <= 1'b0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_phase    <= '0;
      r_gap      <= '0;
      r_sync     <= 1'b1;
      r_sclk     <= 1'b1;
      r_din      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_buf_data <= s_if.sample;
        r_buf_full <= 1'b1;
      end else if (w_load) begin
        r_buf_full <= 1'b0;
      end

      if (w_load) begin
        r_state <= START;
        r_shift <= w_frame;
        r_phase <= '0;
        r_sync  <= 1'b0;
        r_sclk  <= 1'b1;
        r_din   <= w_frame[15];
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            r_sync <= 1'b1;
            r_sclk <= 1'b1;
            r_din  <= 1'b0;
            r_busy <= 1'b0;
          end
          START: begin
            if (w_phase_end) begin
              r_phase   <= '0;
              r_state   <= SHIFT;
              r_sclk    <= 1'b0;
              r_bit_cnt <= 4'd15;
            end else begin
              r_phase <= r_phase + PW'(1);
            end
          end
          SHIFT: begin
            if (!w_phase_end) begin
              r_phase <= r_phase + PW'(1);
            end else begin
              r_phase <= '0;
              // DIN only advances on SCLK rising edges, so the DAC falling-edge sample is always stable
              if (!r_sclk) begin
                r_sclk <= 1'b1;
                if (r_bit_cnt == 4'd0) begin
                  r_state <= GAP;
                  r_sync  <= 1'b1;
                  r_din   <= 1'b0;
                  r_gap   <= '0;
                end else begin
                  r_din     <= r_shift[14];
                  r_shift   <= {r_shift[14:0], 1'b0};
                  r_bit_cnt <= r_bit_cnt - 4'd1;
                end
              end else begin
                r_sclk <= 1'b0;
              end
            end
          end
          GAP: begin
            if (w_gap_end) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_gap   <= '0;
            end else begin
              r_gap <= r_gap + GW'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_output_serial.sv
// tb/tb_audio_output_serial.sv - scoreboard bench for audio_output_serial (default and fastest parameter sets)
module tb_audio_output_serial;

  localparam int HP0 = 5;
  localparam int HP1 = 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset0, reset1;
  logic busy0, sync0, din0, sclk0;
  logic busy1, sync1, din1, sclk1;

  audio_output_serial_if if0 ();
  audio_output_serial_if if1 ();

  audio_output_serial dut0 (
    .clock(clock), .reset(reset0), .s_if(if0.slave),
    .busy(busy0), .J_DA_Pin1(sync0), .J_DA_Pin2(din0), .J_DA_Pin4(sclk0)
  );

  audio_output_serial #(.HALF_PERIOD(1), .GAP_CYCLES(1), .PD_MODE(2'b11)) dut1 (
    .clock(clock), .reset(reset1), .s_if(if1.slave),
    .busy(busy1), .J_DA_Pin1(sync1), .J_DA_Pin2(din1), .J_DA_Pin4(sclk1)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  int          gap_q0[$];
  int          gap_q1[$];

  int          low_cnt[2];
  int          high_cnt[2];
  int          falls[2];
  logic [15:0] cap[2];
  logic [15:0] last_cap[2];
  logic        ps[2];
  logic        pk[2];
  logic        abort_f[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic frame_end(input int id);
    int          depth;
    logic [15:0] e;
    check_eq(id == 0 ? "sync_low_cycles0" : "sync_low_cycles1", low_cnt[id], 32 * (id == 0 ? HP0 : HP1));
    check_eq(id == 0 ? "sclk_falls0" : "sclk_falls1", falls[id], 16);
    last_cap[id] = cap[id];
    depth = (id == 0) ? exp_q0.size() : exp_q1.size();
    check_eq("frame_expected", depth > 0, 1);
    if (depth > 0) begin
      e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check_eq(id == 0 ? "frame_bits0" : "frame_bits1", cap[id], e);
    end
  endtask

  task automatic mon_step(input int id, input logic s, input logic k, input logic d);
    if (!s) begin
      if (ps[id]) begin
        if (id == 0) gap_q0.push_back(high_cnt[id]);
        else gap_q1.push_back(high_cnt[id]);
        low_cnt[id] = 0;
        falls[id]   = 0;
        cap[id]     = '0;
      end
      low_cnt[id]++;
      if (pk[id] && !k) begin
        falls[id]++;
        cap[id] = {cap[id][14:0], d};
      end
    end else begin
      if (!ps[id]) begin
        if (abort_f[id]) abort_f[id] = 1'b0;
        else frame_end(id);
        high_cnt[id] = 0;
      end
      high_cnt[id]++;
    end
    ps[id] = s;
    pk[id] = k;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      low_cnt[i] = 0; high_cnt[i] = 0; falls[i] = 0;
      cap[i] = '0; last_cap[i] = '0; ps[i] = 1'b1; pk[i] = 1'b1; abort_f[i] = 1'b0;
    end
  end

  always @(negedge clock) begin
    mon_step(0, sync0, sclk0, din0);
    mon_step(1, sync1, sclk1, din1);
  end

  task automatic send(input int id, input logic [11:0] d);
    int   n;
    logic r;
    n = 0;
    if (id == 0) begin if0.sample = d; if0.sample_valid = 1'b1; end
    else begin if1.sample = d; if1.sample_valid = 1'b1; end
    do begin
      @(negedge clock);
      r = (id == 0) ? if0.sample_ready : if1.sample_ready;
      n++;
    end while (!r && n < 2000);
    check_eq("accept_in_time", r, 1'b1);
    if (id == 0) exp_q0.push_back({2'b00, 2'b00, d});
    else exp_q1.push_back({2'b00, 2'b11, d});
    @(posedge clock); #1;
    check_eq("ready_low_after_accept", (id == 0) ? if0.sample_ready : if1.sample_ready, 1'b0);
  endtask

  task automatic wait_idle(input int id);
    int n;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (((id == 0) ? (busy0 || exp_q0.size() != 0 || !if0.sample_ready)
                          : (busy1 || exp_q1.size() != 0 || !if1.sample_ready)) && n < 5000);
    check_eq("idle_in_time", n < 5000, 1'b1);
  endtask

  initial begin
    int n;
    int bad;
    reset0 = 1'b1; reset1 = 1'b1;
    if0.sample = '0; if0.sample_valid = 1'b1;
    if1.sample = '0; if1.sample_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_ready", if0.sample_ready, 1'b1);
    check_eq("rst_busy", busy0, 1'b0);
    check_eq("rst_sync", sync0, 1'b1);
    check_eq("rst_sclk", sclk0, 1'b1);
    check_eq("rst_din", din0, 1'b0);
    if0.sample_valid = 1'b0;
    reset0 = 1'b0; reset1 = 1'b0;
    @(posedge clock); #1;

    // single sample: start latency and busy duration
    send(0, 12'hA5C);
    if0.sample_valid = 1'b0;
    check_eq("sync_high_on_accept", sync0, 1'b1);
    @(posedge clock); #1;
    check_eq("start_sync_low", sync0, 1'b0);
    check_eq("start_busy", busy0, 1'b1);
    n = 0;
    while (busy0 && n < 1000) begin
      n++;
      @(posedge clock); #1;
    end
    check_eq("busy_cycles", n, 170);
    wait_idle(0);
    check_eq("single_frame_bits", last_cap[0], 16'h0A5C);

    // back-to-back with valid held high
    gap_q0.delete();
    send(0, 12'h800);
    send(0, 12'hFFF);
    send(0, 12'h001);
    if0.sample_valid = 1'b0;
    wait_idle(0);
    check_eq("b2b_frames", gap_q0.size(), 3);
    if (gap_q0.size() >= 3) begin
      check_eq("b2b_gap1", gap_q0[1], 10);
      check_eq("b2b_gap2", gap_q0[2], 10);
    end

    // backpressure: 12'h123 offered while the buffer is full must be ignored
    send(0, 12'h111);
    if0.sample_valid = 1'b0;
    n = 0;
    while (sync0 && n < 100) begin n++; @(posedge clock); #1; end
    send(0, 12'h222);
    if0.sample = 12'h123;
    bad = 0;
    repeat (50) begin
      @(negedge clock);
      if (if0.sample_ready) bad++;
    end
    check_eq("bp_ready_low", bad, 0);
    @(posedge clock); #1;
    if0.sample_valid = 1'b0;
    wait_idle(0);
    check_eq("bp_held_sample_sent", last_cap[0], 16'h0222);

    // sample offered across the IDLE->START edge
    send(0, 12'h0AB);
    send(0, 12'h7FF);
    if0.sample_valid = 1'b0;
    wait_idle(0);
    check_eq("sim_load_accept", last_cap[0], 16'h07FF);

    // mid-frame reset after 8 SCLK falls
    send(0, 12'h5A5);
    if0.sample_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(!sync0 && falls[0] >= 8 && falls[0] < 16) && n < 1000);
    check_eq("reached_8_falls", n < 1000, 1'b1);
    reset0 = 1'b1;
    abort_f[0] = 1'b1;
    exp_q0.delete();
    @(posedge clock); #1;
    check_eq("abort_sync", sync0, 1'b1);
    check_eq("abort_sclk", sclk0, 1'b1);
    check_eq("abort_din", din0, 1'b0);
    check_eq("abort_ready", if0.sample_ready, 1'b1);
    check_eq("abort_busy", busy0, 1'b0);
    reset0 = 1'b0;
    bad = 0;
    repeat (60) begin
      @(posedge clock); #1;
      if (!sclk0 || !sync0 || busy0) bad++;
    end
    check_eq("abort_no_activity", bad, 0);
    send(0, 12'h3C3);
    if0.sample_valid = 1'b0;
    wait_idle(0);
    check_eq("post_abort_frame", last_cap[0], 16'h03C3);

    // fastest parameter set
    gap_q1.delete();
    send(1, 12'hABC);
    send(1, 12'h123);
    if1.sample_valid = 1'b0;
    wait_idle(1);
    check_eq("fast_frames", gap_q1.size(), 2);
    if (gap_q1.size() >= 2) check_eq("fast_gap", gap_q1[1], 1);
    check_eq("fast_pd_bits", last_cap[1][13:12], 2'b11);

    check_eq("q0_drained", exp_q0.size(), 0);
    check_eq("q1_drained", exp_q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
